pool_1: RTL and testbench

POOL_1 -- requirements
Module: pool_1

---
 rtl/lenet_pkg.sv | 21 ++
 rtl/pool_max4.sv | 22 ++
 rtl/pool_1.sv | 139 +++++++++++++
 tb/tb_pool_1.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// lenet_pkg: dimensions and types shared by the LeNet feature-map blocks.
package lenet_pkg;

   localparam int DW           = 16;
   localparam int FM1_CH       = 6;
   localparam int FM1_ROWPAIRS = 14;
   localparam int FM1_LANES    = 56;
   localparam int POOL1_LANES  = 14;

   // One word per (channel, row pair); the last word closes a pass.
   localparam int              FM1_WORDS = FM1_CH * FM1_ROWPAIRS;
   localparam logic [6:0]      LAST_ADDR = 7'(FM1_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } pool1_state_e;

endpackage

// File: rtl/pool_max4.sv
// pool_max4: combinational signed maximum of four DW-bit values.
module pool_max4 #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] c,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] y
);

   logic [DW-1:0] ab;
   logic [DW-1:0] cd;

   // Two-level tree of signed compares; on a tie either operand is the same value.
   always_comb begin
      ab = ($signed(a) > $signed(b))  ? a  : b;
      cd = ($signed(c) > $signed(d))  ? c  : d;
      y  = ($signed(ab) > $signed(cd)) ? ab : cd;
   end

endmodule

// File: rtl/pool_1.sv
// pool_1: 2x2 max pooling of the conv_1 map (6 x 28x28 -> 6 x 14x14).
// Each input word holds a row pair; each one produces one pooled output row
// at the same word address. Reads stream one per cycle, writes follow
// RD_LAT+1 cycles later through a valid/address shift register.
module pool_1 #(
   parameter int DW      = lenet_pkg::DW,
   parameter int RD_LAT  = 2,
   parameter bit RELU_EN = 1'b0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 pool_1_en,
   output logic                                 fm_bram_1_en,
   output logic [6:0]                           fm_bram_1_addr,
   input  logic [lenet_pkg::FM1_LANES*DW-1:0]   fm_bram_1_dout,
   output logic                                 fm_bram_2_we,
   output logic [6:0]                           fm_bram_2_addr,
   output logic [lenet_pkg::POOL1_LANES*DW-1:0] fm_bram_2_din,
   output logic                                 pool_1_busy,
   output logic                                 pool_1_finish
);

   import lenet_pkg::*;

   localparam int HALF = FM1_LANES / 2;

   pool1_state_e state_q, state_d;
   logic         en_prev_q, en_prev_d;
   logic [6:0]   rd_addr_q, rd_addr_d;
   logic [RD_LAT:0] vld_q, vld_d;
   logic [6:0]   wa_q [RD_LAT+1];
   logic [6:0]   wa_d [RD_LAT+1];
   logic [POOL1_LANES*DW-1:0] din_q, din_d;
   logic [POOL1_LANES*DW-1:0] pooled;
   logic         start;
   logic         abort;
   logic         last_wr;

   // Fourteen 2x2 windows: lanes 2m, 2m+1 of the upper row and the same
   // columns of the lower row, optionally clamped at zero.
   for (genvar m = 0; m < POOL1_LANES; m++) begin : g_lane
      logic [DW-1:0] mx;
      pool_max4 #(.DW(DW)) u_max (
         .a (fm_bram_1_dout[(2*m)*DW        +: DW]),
         .b (fm_bram_1_dout[(2*m+1)*DW      +: DW]),
         .c (fm_bram_1_dout[(HALF+2*m)*DW   +: DW]),
         .d (fm_bram_1_dout[(HALF+2*m+1)*DW +: DW]),
         .y (mx)
      );
      assign pooled[m*DW +: DW] = (RELU_EN && mx[DW-1]) ? '0 : mx;
   end

   assign start   = pool_1_en & ~en_prev_q;
   assign last_wr = vld_q[RD_LAT] && (wa_q[RD_LAT] == LAST_ADDR);

   // Next-state logic; dropping the enable mid-pass returns to IDLE and
   // flags an abort that flushes the write pipeline.
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      abort     = 1'b0;
      en_prev_d = pool_1_en;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_READ;
         end
         ST_READ: begin
            if (!pool_1_en) begin
               state_d   = ST_IDLE;
               abort     = 1'b1;
               rd_addr_d = '0;
            end else if (rd_addr_q == LAST_ADDR) begin
               state_d   = ST_DRAIN;
               rd_addr_d = '0;
            end else begin
               rd_addr_d = rd_addr_q + 7'd1;
            end
         end
         ST_DRAIN: begin
            if (!pool_1_en) begin
               state_d = ST_IDLE;
               abort   = 1'b1;
            end else if (last_wr) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!pool_1_en) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Valid/address shift register: stage RD_LAT-1 lines up with read data,
   // stage RD_LAT lines up with the registered pooled row.
   always_comb begin
      vld_d   = {vld_q[RD_LAT-1:0], fm_bram_1_en};
      wa_d[0] = rd_addr_q;
      for (int i = 1; i <= RD_LAT; i++) wa_d[i] = wa_q[i-1];
      if (abort) begin
         vld_d = '0;
         for (int i = 0; i <= RD_LAT; i++) wa_d[i] = '0;
      end
   end

   // Capture the pooled row in the cycle its read data is valid.
   always_comb begin
      din_d = din_q;
      if (vld_q[RD_LAT-1]) din_d = pooled;
   end

   // State and pipeline registers; en_prev_q follows the enable even during
   // reset so a level held through reset is not taken as a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rd_addr_q <= '0;
         vld_q     <= '0;
         din_q     <= '0;
         for (int i = 0; i <= RD_LAT; i++) wa_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         vld_q     <= vld_d;
         din_q     <= din_d;
         for (int i = 0; i <= RD_LAT; i++) wa_q[i] <= wa_d[i];
      end
      en_prev_q <= en_prev_d;
   end

   assign fm_bram_1_en   = (state_q == ST_READ);
   assign fm_bram_1_addr = rd_addr_q;
   assign fm_bram_2_we   = vld_q[RD_LAT];
   assign fm_bram_2_addr = wa_q[RD_LAT];
   assign fm_bram_2_din  = din_q;
   assign pool_1_busy    = (state_q == ST_READ) || (state_q == ST_DRAIN);
   assign pool_1_finish  = (state_q == ST_DONE);

endmodule

// File: tb/tb_pool_1.sv
// tb_pool_1: randomized passes of pool_1 against a behavioural pooling model,
// with a plain and a ReLU instance sharing one modelled input BRAM.
module tb_pool_1;

   localparam int W   = 16;
   localparam int LAT = 2;
   localparam int IW  = 56 * W;
   localparam int OW  = 14 * W;
   localparam int NW  = 84;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   logic pool_1_en;
   always #5 clk = ~clk;

   logic          fm_bram_1_en, r_rd_en;
   logic [6:0]    fm_bram_1_addr, r_rd_addr;
   logic [IW-1:0] fm_bram_1_dout;
   logic          fm_bram_2_we, r_we;
   logic [6:0]    fm_bram_2_addr, r_wa;
   logic [OW-1:0] fm_bram_2_din, r_din;
   logic          pool_1_busy, r_busy;
   logic          pool_1_finish, r_finish;

   pool_1 #(.DW(W), .RD_LAT(LAT), .RELU_EN(1'b0)) dut (
      .clk(clk), .rst(rst), .pool_1_en(pool_1_en),
      .fm_bram_1_en(fm_bram_1_en), .fm_bram_1_addr(fm_bram_1_addr),
      .fm_bram_1_dout(fm_bram_1_dout),
      .fm_bram_2_we(fm_bram_2_we), .fm_bram_2_addr(fm_bram_2_addr),
      .fm_bram_2_din(fm_bram_2_din),
      .pool_1_busy(pool_1_busy), .pool_1_finish(pool_1_finish)
   );

   pool_1 #(.DW(W), .RD_LAT(LAT), .RELU_EN(1'b1)) dut_relu (
      .clk(clk), .rst(rst), .pool_1_en(pool_1_en),
      .fm_bram_1_en(r_rd_en), .fm_bram_1_addr(r_rd_addr),
      .fm_bram_1_dout(fm_bram_1_dout),
      .fm_bram_2_we(r_we), .fm_bram_2_addr(r_wa),
      .fm_bram_2_din(r_din),
      .pool_1_busy(r_busy), .pool_1_finish(r_finish)
   );

   // ---------------- input BRAM model ----------------
   logic [IW-1:0] mem [NW];
   logic [IW-1:0] rd_pipe [LAT];

   always @(posedge clk) begin
      if (fm_bram_1_en) rd_pipe[0] <= (fm_bram_1_addr < 7'd84) ? mem[fm_bram_1_addr] : '0;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign fm_bram_1_dout = rd_pipe[LAT-1];

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: each output lane is the signed max of its 2x2 window.
   function automatic logic [OW-1:0] pool_ref(input logic [IW-1:0] w, input bit relu);
      logic [OW-1:0] r;
      logic [W-1:0]  e;
      int best, v, idx;
      r = '0;
      for (int m = 0; m < 14; m++) begin
         best = -100000;
         for (int k = 0; k < 4; k++) begin
            idx = (k < 2) ? (2*m + k) : (26 + 2*m + k);
            e = w[idx*W +: W];
            v = $signed(e);
            if (v > best) best = v;
         end
         if (relu && best < 0) best = 0;
         r[m*W +: W] = best[W-1:0];
      end
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   logic [6:0]    exp_q[$];
   int            cyc = 0;
   int            start_cyc = 0;
   int            wr_cnt = 0;
   bit            mon_en = 1'b0;
   logic [6:0]    mon_a;
   logic [OW-1:0] got_din   [NW];
   logic [OW-1:0] got_din_r [NW];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_en) begin
         if (fm_bram_2_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_write", 256'(fm_bram_2_we), 256'(0));
            end else begin
               mon_a = exp_q.pop_front();
               check("wr_addr", 256'(fm_bram_2_addr), 256'(mon_a));
               check("wr_time", 256'(cyc), 256'(start_cyc + int'(mon_a) + LAT + 1));
               check("wr_din", 256'(fm_bram_2_din), 256'(pool_ref(mem[mon_a], 1'b0)));
               check("relu_wr", 256'({r_we, r_wa}), 256'({1'b1, mon_a}));
               check("relu_din", 256'(r_din), 256'(pool_ref(mem[mon_a], 1'b1)));
               got_din[mon_a]   = fm_bram_2_din;
               got_din_r[mon_a] = r_din;
            end
         end else begin
            check("relu_idle_we", 256'(r_we), 256'(0));
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic logic [W-1:0] rand_elem();
      case ($urandom_range(0, 5))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic fill_random();
      for (int a = 0; a < NW; a++)
         for (int j = 0; j < 56; j++) mem[a][j*W +: W] = rand_elem();
   endtask

   // Raise the enable and stop at the first READ cycle (one edge in).
   task automatic start_pass();
      exp_q.delete();
      for (int a = 0; a < NW; a++) exp_q.push_back(7'(a));
      wr_cnt = 0;
      mon_en = 1'b1;
      @(negedge clk);
      pool_1_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_cyc = cyc;
      check("start_busy", 256'({pool_1_busy, pool_1_finish}), 256'(2'b10));
      check("start_rd", 256'({fm_bram_1_en, fm_bram_1_addr, r_rd_en, r_rd_addr}),
            256'({1'b1, 7'd0, 1'b1, 7'd0}));
   endtask

   // Run the rest of the pass, check timing and DONE hold, then release.
   task automatic finish_pass();
      int cnt;
      cnt = 1;
      while (!pool_1_finish && cnt < 300) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
         if (cnt <= 84)
            check("rd_req", 256'({fm_bram_1_en, fm_bram_1_addr, r_rd_en, r_rd_addr}),
                  256'({1'b1, 7'(cnt-1), 1'b1, 7'(cnt-1)}));
         if (cnt == 85) check("drain_state", 256'({fm_bram_1_en, pool_1_busy}), 256'(2'b01));
      end
      check("pass_cycles", 256'(cnt), 256'(84 + LAT + 2));
      check("wr_count", 256'(wr_cnt), 256'(NW));
      check("exp_q_empty", 256'(exp_q.size()), 256'(0));
      check("done_flags", 256'({pool_1_busy, pool_1_finish, r_busy, r_finish}), 256'(4'b0101));
      repeat (8) begin
         @(negedge clk);
         check("done_hold", 256'({pool_1_busy, pool_1_finish, fm_bram_1_en}), 256'(3'b010));
      end
      pool_1_en = 1'b0;
      @(negedge clk);
      check("done_release", 256'({pool_1_busy, pool_1_finish}), 256'(0));
      mon_en = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int n;
      int cnt;
      rst       = 1'b1;
      pool_1_en = 1'b0;
      for (int a = 0; a < NW; a++) mem[a] = '0;
      repeat (4) @(negedge clk);
      check("reset_ctrl", 256'({fm_bram_1_en, fm_bram_1_addr, fm_bram_2_we, fm_bram_2_addr,
                                pool_1_busy, pool_1_finish}), 256'(0));
      check("reset_din", 256'(fm_bram_2_din), 256'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Pass 1: ramp data, lane j of word a = a*64 + j.
      for (int a = 0; a < NW; a++)
         for (int j = 0; j < 56; j++) mem[a][j*W +: W] = 16'(a*64 + j);
      start_pass();
      finish_pass();
      for (int a = 0; a < NW; a += 41)
         for (int m = 0; m < 14; m += 6)
            check("ramp_lane", 256'(got_din[a][m*W +: W]), 256'(16'(a*64 + 29 + 2*m)));

      // Pass 2: random data with two hand-built words.
      fill_random();
      for (int m = 0; m < 14; m++) begin
         mem[10][(2*m)*W    +: W] = 16'hFFFB;
         mem[10][(2*m+1)*W  +: W] = 16'hFFFD;
         mem[10][(28+2*m)*W +: W] = 16'hFFF9;
         mem[10][(29+2*m)*W +: W] = 16'hFFF7;
         mem[11][(2*m)*W    +: W] = 16'h8000;
         mem[11][(2*m+1)*W  +: W] = 16'h8000;
         mem[11][(28+2*m)*W +: W] = 16'h8000;
         mem[11][(29+2*m)*W +: W] = 16'h7FFF;
      end
      start_pass();
      finish_pass();
      check("neg_word", 256'(got_din[10]), 256'({14{16'hFFFD}}));
      check("neg_word_relu", 256'(got_din_r[10]), 256'(0));
      check("extreme_word", 256'(got_din[11]), 256'({14{16'h7FFF}}));

      // Pass 3: reset around write 50, enable held high through reset.
      fill_random();
      start_pass();
      n = 0;
      while (wr_cnt < 50 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("wr50_reached", 256'(n < 200), 256'(1));
      rst    = 1'b1;
      mon_en = 1'b0;
      @(negedge clk);
      check("midrst_ctrl", 256'({fm_bram_1_en, fm_bram_1_addr, fm_bram_2_we, fm_bram_2_addr,
                                 pool_1_busy, pool_1_finish, r_we}), 256'(0));
      check("midrst_din", 256'(fm_bram_2_din), 256'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("post_rst_idle", 256'({fm_bram_1_en, fm_bram_2_we, pool_1_busy, pool_1_finish}),
               256'(0));
      end
      pool_1_en = 1'b0;
      @(negedge clk);

      // Pass 4: abort by dropping the enable in READ cycle 40.
      fill_random();
      start_pass();
      cnt = 1;
      while (cnt < 41) begin
         @(negedge clk);
         cnt++;
      end
      check("abort_busy", 256'(pool_1_busy), 256'(1));
      pool_1_en = 1'b0;
      mon_en    = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("abort_quiet", 256'({fm_bram_1_en, fm_bram_2_we, pool_1_busy, pool_1_finish, r_we}),
               256'(0));
      end

      // Pass 5: a fresh edge restarts from address 0.
      fill_random();
      start_pass();
      finish_pass();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
